// File: rtl/sync_fifo_hs_pkg.sv
// Shared helpers for the capture-path buffers: occupancy/pointer widths,
// wrap-around pointer increment and the read-port style encoding.
package sync_fifo_hs_pkg;

    // Read-port style: registered output or first-word-fall-through.
    typedef enum logic [0:0] {
        FIFO_REGISTERED = 1'b0,
        FIFO_FWFT       = 1'b1
    } fifo_type_e;

    // Bits needed to hold an occupancy value in 0..depth.
    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address depth entries (at least one bit).
    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Next pointer value, wrapping depth-1 back to 0 so any depth works.
    function automatic int unsigned ptrNext(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage : sync_fifo_hs_pkg

// File: rtl/sync_fifo_hs.sv
// Single-clock valid/ready FIFO with occupancy flags.
// FIFO_TYPE 1 shows the head entry on data_o (FWFT); FIFO_TYPE 0 loads data_o
// from the head on each pop. Depth may be any integer >= 2.
// Optional: define SYNC_FIFO_ERR_FLAG_EN to add the sticky err_o output that
// flags a write while full or a read while empty.
module sync_fifo_hs
    import sync_fifo_hs_pkg::*;
#(
    parameter int FIFO_TYPE        = 1,
    parameter int DATA_WIDTH       = 8,
    parameter int FIFO_DEPTH       = 4,
    parameter int ALMOST_EMPTY_LVL = 1,
    parameter int ALMOST_FULL_LVL  = FIFO_DEPTH - 1
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic [DATA_WIDTH-1:0]            data_i,
    input  logic                             wr_valid_i,
    output logic                             wr_ready_o,
    output logic [DATA_WIDTH-1:0]            data_o,
    output logic                             rd_ready_o,
    input  logic                             rd_valid_i,
    output logic                             empty_o,
    output logic                             full_o,
    output logic                             almost_empty_o,
    output logic                             almost_full_o,
    output logic [cntWidth(FIFO_DEPTH)-1:0]  counter
`ifdef SYNC_FIFO_ERR_FLAG_EN
    ,
    output logic                             err_o
`endif
);

    localparam int CNT_W = cntWidth(FIFO_DEPTH);
    localparam int PTR_W = ptrWidth(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(ALMOST_EMPTY_LVL);
    localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(ALMOST_FULL_LVL);
    localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic                  push;
    logic                  pop;

    // Requests against a full/empty FIFO are dropped; flags come from the counter only,
    // so a pop never frees space for a push in the same cycle.
    assign push = wr_valid_i & ~full_o;
    assign pop  = rd_valid_i & ~empty_o;

    assign empty_o        = (counter == '0);
    assign full_o         = (counter == DEPTH_CNT);
    assign wr_ready_o     = ~full_o;
    assign rd_ready_o     = ~empty_o;
    assign almost_empty_o = (counter <= AEMPTY_CNT);
    assign almost_full_o  = (counter >= AFULL_CNT);

    // Pointer and occupancy bookkeeping; reset discards all stored words.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            counter <= '0;
        end else begin
            if (push) begin
                wrPtr <= PTR_W'(ptrNext(32'(wrPtr), FIFO_DEPTH));
            end
            if (pop) begin
                rdPtr <= PTR_W'(ptrNext(32'(rdPtr), FIFO_DEPTH));
            end
            case ({push, pop})
                2'b10:   counter <= counter + ONE_CNT;
                2'b01:   counter <= counter - ONE_CNT;
                default: counter <= counter;
            endcase
        end
    end

    // Storage array: data only, not touched by reset.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wrPtr] <= data_i;
        end
    end

    generate
        if (FIFO_TYPE == int'(FIFO_FWFT)) begin : gFwft
            // Head entry is always presented; a new word shows one cycle after its push.
            assign data_o = mem[rdPtr];
        end else begin : gRegRead
            logic [DATA_WIDTH-1:0] readData_p1;

            // Output register captures the head on pop and holds it until the next pop.
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    readData_p1 <= '0;
                end else if (pop) begin
                    readData_p1 <= mem[rdPtr];
                end
            end

            assign data_o = readData_p1;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_FLAG_EN
    // Sticky error: set the cycle after any illegal request, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            err_o <= 1'b0;
        end else if ((wr_valid_i & full_o) | (rd_valid_i & empty_o)) begin
            err_o <= 1'b1;
        end
    end
`endif

endmodule : sync_fifo_hs

// File: tb/tb_sync_fifo_hs.sv
// Bench for sync_fifo_hs: a depth-2 FWFT instance and a depth-5 registered-read
// instance, driven by directed and random handshakes and scored against queue models.
module tb_sync_fifo_hs;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Reset;

    // Instance A: FWFT, depth 2
    logic [7:0] dInA, dOutA;
    logic       wvA, rvA, wrA, rrA, emA, fuA, aeA, afA;
    logic [1:0] cntA;
`ifdef SYNC_FIFO_ERR_FLAG_EN
    logic       errA;
`endif

    // Instance B: registered read, depth 5
    logic [7:0] dInB, dOutB;
    logic       wvB, rvB, wrB, rrB, emB, fuB, aeB, afB;
    logic [2:0] cntB;
`ifdef SYNC_FIFO_ERR_FLAG_EN
    logic       errB;
`endif

    sync_fifo_hs #(
        .FIFO_TYPE(1), .DATA_WIDTH(8), .FIFO_DEPTH(2),
        .ALMOST_EMPTY_LVL(1), .ALMOST_FULL_LVL(1)
    ) dutA (
        .Clk(Clk), .Reset(Reset), .data_i(dInA), .wr_valid_i(wvA), .wr_ready_o(wrA),
        .data_o(dOutA), .rd_ready_o(rrA), .rd_valid_i(rvA), .empty_o(emA), .full_o(fuA),
        .almost_empty_o(aeA), .almost_full_o(afA), .counter(cntA)
`ifdef SYNC_FIFO_ERR_FLAG_EN
        , .err_o(errA)
`endif
    );

    sync_fifo_hs #(
        .FIFO_TYPE(0), .DATA_WIDTH(8), .FIFO_DEPTH(5),
        .ALMOST_EMPTY_LVL(1), .ALMOST_FULL_LVL(4)
    ) dutB (
        .Clk(Clk), .Reset(Reset), .data_i(dInB), .wr_valid_i(wvB), .wr_ready_o(wrB),
        .data_o(dOutB), .rd_ready_o(rrB), .rd_valid_i(rvB), .empty_o(emB), .full_o(fuB),
        .almost_empty_o(aeB), .almost_full_o(afB), .counter(cntB)
`ifdef SYNC_FIFO_ERR_FLAG_EN
        , .err_o(errB)
`endif
    );

    int checks = 0;
    int errors = 0;
    int popsA  = 0;

    logic [7:0] mqA[$];   // model contents of A
    logic [7:0] mqB[$];   // model contents of B
    logic [7:0] expA[$];  // words A must deliver, in order
    logic [7:0] expB[$];  // words B must deliver, in order
    bit errMA = 1'b0;
    bit errMB = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Flags follow from the occupancy held in the model.
    task automatic chkFlags(input string tag, input int n, input int depth, input int ae, input int af,
                            input logic [2:0] cnt, input logic em, input logic fu, input logic wr,
                            input logic rr, input logic aeo, input logic afo);
        chk({tag, "_counter"}, 32'(cnt), 32'(n));
        chk({tag, "_empty"}, 32'(em), 32'(n == 0));
        chk({tag, "_full"}, 32'(fu), 32'(n == depth));
        chk({tag, "_wr_ready"}, 32'(wr), 32'(n < depth));
        chk({tag, "_rd_ready"}, 32'(rr), 32'(n > 0));
        chk({tag, "_almost_empty"}, 32'(aeo), 32'(n <= ae));
        chk({tag, "_almost_full"}, 32'(afo), 32'(n >= af));
    endtask

    // One clock of stimulus on A; entered and left #1 after a rising edge.
    task automatic stepA(input bit wv, input logic [7:0] d, input bit rv);
        int  n;
        bit  doPop, doPush;
        wvA = wv; dInA = d; rvA = rv;
        n = mqA.size();
        doPop  = rv && (n > 0);
        doPush = wv && (n < 2);
        if (doPop) expA.push_back(mqA[0]);
        @(negedge Clk);
        chkFlags("A", n, 2, 1, 1, {1'b0, cntA}, emA, fuA, wrA, rrA, aeA, afA);
`ifdef SYNC_FIFO_ERR_FLAG_EN
        chk("A_err", 32'(errA), 32'(errMA));
`endif
        if (doPop) void'(mqA.pop_front());
        if (doPush) mqA.push_back(d);
        if ((wv && n == 2) || (rv && n == 0)) errMA = 1'b1;
        @(posedge Clk); #1;
        wvA = 1'b0; rvA = 1'b0;
    endtask

    // One clock of stimulus on B.
    task automatic stepB(input bit wv, input logic [7:0] d, input bit rv);
        int  n;
        bit  doPop, doPush;
        wvB = wv; dInB = d; rvB = rv;
        n = mqB.size();
        doPop  = rv && (n > 0);
        doPush = wv && (n < 5);
        if (doPop) expB.push_back(mqB[0]);
        @(negedge Clk);
        chkFlags("B", n, 5, 1, 4, cntB, emB, fuB, wrB, rrB, aeB, afB);
`ifdef SYNC_FIFO_ERR_FLAG_EN
        chk("B_err", 32'(errB), 32'(errMB));
`endif
        if (doPop) void'(mqB.pop_front());
        if (doPush) mqB.push_back(d);
        if ((wv && n == 5) || (rv && n == 0)) errMB = 1'b1;
        @(posedge Clk); #1;
        wvB = 1'b0; rvB = 1'b0;
    endtask

    // Two-cycle reset; all buffered words are lost.
    task automatic doReset();
        Reset = 1'b1;
        wvA = 1'b0; rvA = 1'b0; wvB = 1'b0; rvB = 1'b0;
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b0;
        mqA.delete(); mqB.delete(); expA.delete(); expB.delete();
        errMA = 1'b0; errMB = 1'b0;
    endtask

    // Monitor: scores every delivered word against the expectation queues.
    initial begin
        bit pendB;
        pendB = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Reset && rvA && rrA) begin
                popsA++;
                if (expA.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL popA_unexpected: got %0h, expected no pop", dOutA);
                end else begin
                    chk("popA_data", 32'(dOutA), 32'(expA.pop_front()));
                end
            end
            if (!Reset && pendB) begin
                if (expB.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL popB_unexpected: got %0h, expected no pop", dOutB);
                end else begin
                    chk("popB_data", 32'(dOutB), 32'(expB.pop_front()));
                end
            end
            pendB = !Reset && rvB && rrB;
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int startPops;
        Reset = 1'b1;
        dInA = '0; dInB = '0; wvA = 0; rvA = 0; wvB = 0; rvB = 0;
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b0;

        // Reset state of both instances
        stepA(0, 8'h00, 0);
        stepB(0, 8'h00, 0);
        chk("B_data_after_reset", 32'(dOutB), 32'h0);

        // Reset mid-fill
        stepA(1, 8'h5A, 0);
        stepA(0, 8'h00, 0);
        doReset();
        stepA(0, 8'h00, 0);

        // Fill/drain depth 2
        stepA(1, 8'hA1, 0);
        stepA(1, 8'hB2, 0);
        stepA(1, 8'hC3, 0);
        stepA(0, 8'h00, 1);
        stepA(0, 8'h00, 1);
        stepA(0, 8'h00, 0);

        // Throughput: 100 words streaming through
        startPops = popsA;
        for (int i = 1; i <= 100; i++) stepA(1, 8'(i), 1);
        stepA(0, 8'h00, 1);
        stepA(0, 8'h00, 0);
        chk("A_throughput_pops", 32'(popsA - startPops), 32'd100);

        // Full boundary: push+pop while full
        stepA(1, 8'h11, 0);
        stepA(1, 8'h22, 0);
        stepA(1, 8'h33, 1);
        stepA(0, 8'h00, 0);
        stepA(0, 8'h00, 1);
        stepA(0, 8'h00, 0);

        // Random traffic on the depth-5 registered-read instance
        for (int i = 0; i < 60; i++) begin
            if (i < 30) stepB($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0);
            else        stepB($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
        end
        stepB(0, 8'h00, 0);
        stepB(0, 8'h00, 0);

        // Sticky error flag (model tracks it when the flag is built in)
        doReset();
        stepA(0, 8'h00, 0);
        stepA(0, 8'h00, 1);
        stepA(0, 8'h00, 0);
        stepA(1, 8'h44, 0);
        stepA(0, 8'h00, 1);
        stepA(0, 8'h00, 0);
        doReset();
        stepA(0, 8'h00, 0);
        stepB(0, 8'h00, 0);

        chk("A_words_left", 32'(expA.size()), 32'd0);
        chk("B_words_left", 32'(expB.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sync_fifo_hs
